button_event_arbiter: RTL

//  Front end for all user pushbuttons. Per channel: 2-FF synchronize the async

---
 rtl/btn_evt_pkg.sv | 11 +
 rtl/btn_debounce_ch.sv | 50 +++++
 rtl/button_event_arbiter.sv | 112 +++++++++++
 3 files changed

// File: rtl/btn_evt_pkg.sv
// Shared defaults and types for the pushbutton event front end.
package btn_evt_pkg;

    localparam int DEF_N_BTN           = 4;
    localparam int DEF_DEBOUNCE_CYCLES = 4;
    localparam int DEF_FIFO_DEPTH      = 4;
    localparam int DEF_CH_W            = $clog2(DEF_N_BTN);

    typedef logic [DEF_CH_W-1:0] btn_idx_t;

endpackage

// File: rtl/btn_debounce_ch.sv
// One button channel: two-flop synchronizer, counting debouncer and a
// registered-previous-level rising edge detector.
module btn_debounce_ch
    import btn_evt_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic nrst,
    input  logic btn_async,
    output logic db_level,
    output logic rise
);

    localparam int DB_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

    logic            meta;
    logic            sync;
    logic            db_prev;
    logic [DB_W-1:0] db_cnt;

    // The level only flips after DEBOUNCE_CYCLES consecutive disagreeing samples.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            meta     <= 1'b0;
            sync     <= 1'b0;
            db_cnt   <= '0;
            db_level <= 1'b0;
            db_prev  <= 1'b0;
        end else begin
            meta    <= btn_async;
            sync    <= meta;
            db_prev <= db_level;
            if (sync != db_level) begin
                if (db_cnt == DB_LAST) begin
                    db_level <= ~db_level;
                    db_cnt   <= '0;
                end else begin
                    db_cnt <= db_cnt + DB_W'(1);
                end
            end else begin
                db_cnt <= '0;
            end
        end
    end

    assign rise = db_level & ~db_prev;

endmodule

// File: rtl/button_event_arbiter.sv
// Pushbutton front end: per-channel debounce, pending/overflow latches,
// round-robin grant into a channel-index FIFO popped by valid/ready.
module button_event_arbiter
    import btn_evt_pkg::*;
#(
    parameter  int N_BTN           = DEF_N_BTN,
    parameter  int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter  int FIFO_DEPTH      = DEF_FIFO_DEPTH,
    localparam int CH_W            = $clog2(N_BTN),
    localparam int CNT_W           = $clog2(FIFO_DEPTH) + 1
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic [N_BTN-1:0] btn_async,
    input  logic             evt_ready,
    input  logic             clr_ovf,
    output logic             evt_valid,
    output logic [CH_W-1:0]  evt_ch,
    output logic [N_BTN-1:0] pending,
    output logic [N_BTN-1:0] ovf,
    output logic [CNT_W-1:0] fifo_count
);

    localparam int PTR_W = CNT_W - 1;

    logic [N_BTN-1:0] db_level;
    logic [N_BTN-1:0] rise;

    for (genvar i = 0; i < N_BTN; i++) begin : g_ch
        btn_debounce_ch #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_ch (
            .clk       (clk),
            .nrst      (nrst),
            .btn_async (btn_async[i]),
            .db_level  (db_level[i]),
            .rise      (rise[i])
        );

        a_rise_high : assert property (@(posedge clk) disable iff (!nrst) rise[i] |-> db_level[i]);
    end

    logic [CH_W-1:0]  rr_ptr;
    logic [CH_W-1:0]  grant_idx;
    logic             grant_any;
    logic [CH_W-1:0]  cand;
    logic [N_BTN-1:0] grant_vec;
    logic             pop;
    logic             push;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CH_W-1:0]  mem [FIFO_DEPTH];

    assign evt_valid = (fifo_count != '0);
    assign evt_ch    = evt_valid ? mem[rd_ptr] : '0;
    assign pop       = evt_valid & evt_ready;

    // Scan from the farthest offset down so the nearest pending channel after rr_ptr wins.
    always_comb begin
        grant_any = 1'b0;
        grant_idx = '0;
        cand      = '0;
        for (int off = N_BTN; off >= 1; off--) begin
            cand = CH_W'((int'(rr_ptr) + off) % N_BTN);
            if (pending[cand]) begin
                grant_any = 1'b1;
                grant_idx = cand;
            end
        end
    end

    always_comb begin
        push      = grant_any && ((fifo_count < CNT_W'(FIFO_DEPTH)) || pop);
        grant_vec = '0;
        if (push) begin
            grant_vec[grant_idx] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            pending    <= '0;
            ovf        <= '0;
            rr_ptr     <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            pending <= rise | (pending & ~grant_vec);
            ovf     <= (clr_ovf ? '0 : ovf) | (rise & pending);
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
                rr_ptr <= grant_idx;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + CNT_W'(1);
                2'b01:   fifo_count <= fifo_count - CNT_W'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= grant_idx;
        end
    end

endmodule
